// File: rtl/camera_capture.sv
// OV7670-style RGB565 byte-stream capture: assembles pixels, packs them to RGB332 and writes them into the frame buffer.
// Optional build macro FRAME_STATS_EN adds per-frame red/blue pixel counters (RED_COUNT, BLUE_COUNT).
module camera_capture #(
  parameter int WIDTH  = 176,
  parameter int HEIGHT = 144,
  parameter int ADDR_W = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        DATA,
  output logic              W_EN,
  output logic [ADDR_W-1:0] WRITE_ADDR,
  output logic [7:0]        PIXEL_DATA,
  output logic              FRAME_DONE,
  output logic [7:0]        X_POS,
  output logic [7:0]        Y_POS
`ifdef FRAME_STATS_EN
  ,
  output logic [ADDR_W-1:0] RED_COUNT,
  output logic [ADDR_W-1:0] BLUE_COUNT
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0]        X_MAX  = 8'(WIDTH);
  localparam logic [7:0]        Y_MAX  = 8'(HEIGHT);
  localparam logic [7:0]        Y_LAST = 8'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

  state_t              state_q, state_d;
  logic                vsync_q, href_q;
  logic                phase_q, phase_d;
  logic [5:0]          hi_q, hi_d;
  logic [7:0]          x_q, x_d;
  logic [7:0]          y_q, y_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic                w_en_q, w_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          pix_q, pix_d;
  logic                done_q, done_d;
  logic                vs_rise_s, vs_fall_s, href_fall_s;

  assign vs_rise_s   = VSYNC & ~vsync_q;
  assign vs_fall_s   = ~VSYNC & vsync_q;
  assign href_fall_s = ~HREF & href_q;

  // Next-state and registered-output decode for the capture FSM.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    x_d     = x_q;
    y_d     = y_q;
    row_d   = row_q;
    w_en_d  = 1'b0;
    addr_d  = addr_q;
    pix_d   = pix_q;
    done_d  = 1'b0;
    if (vs_rise_s) begin
      // A new frame start always wins, even mid-pixel; the half pixel is dropped.
      state_d = ST_SYNC;
      phase_d = 1'b0;
      x_d     = 8'd0;
      y_d     = 8'd0;
      row_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SYNC: begin
          phase_d = 1'b0;
          x_d     = 8'd0;
          y_d     = 8'd0;
          row_d   = '0;
          if (vs_fall_s) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_ACTIVE: begin
          if (HREF) begin
            if (!phase_q) begin
              hi_d    = {DATA[7:5], DATA[2:0]};
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if ((x_q < X_MAX) && (y_q < Y_MAX)) begin
                w_en_d = 1'b1;
                pix_d  = {hi_q, DATA[4:3]};
                addr_d = row_q + ADDR_W'(x_q);
              end else begin
                w_en_d = 1'b0;
              end
              if (x_q < X_MAX) begin
                x_d = x_q + 8'd1;
              end else begin
                x_d = X_MAX;
              end
            end
          end else if (href_fall_s) begin
            x_d     = 8'd0;
            phase_d = 1'b0;
            if (y_q == Y_LAST) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              y_d   = y_q + 8'd1;
              row_d = row_q + ROW_STEP;
            end
          end else begin
            state_d = ST_ACTIVE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, position and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      phase_q <= 1'b0;
      hi_q    <= 6'd0;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      row_q   <= '0;
      w_en_q  <= 1'b0;
      addr_q  <= '0;
      pix_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= VSYNC;
      href_q  <= HREF;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      x_q     <= x_d;
      y_q     <= y_d;
      row_q   <= row_d;
      w_en_q  <= w_en_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      done_q  <= done_d;
    end
  end

  assign W_EN       = w_en_q;
  assign WRITE_ADDR = addr_q;
  assign PIXEL_DATA = pix_q;
  assign FRAME_DONE = done_q;
  assign X_POS      = x_q;
  assign Y_POS      = y_q;

`ifdef FRAME_STATS_EN
  function automatic logic is_red(input logic [2:0] r, input logic [1:0] b);
    return (r >= 3'b110) && (b == 2'b00);
  endfunction

  function automatic logic is_blue(input logic [2:0] r, input logic [1:0] b);
    return (b == 2'b11) && (r <= 3'b001);
  endfunction

  logic [ADDR_W-1:0] red_acc_q, red_acc_d, blue_acc_q, blue_acc_d;
  logic [ADDR_W-1:0] red_out_q, red_out_d, blue_out_q, blue_out_d;

  // Accumulate on each issued write; publish the totals alongside FRAME_DONE.
  always_comb begin
    red_acc_d  = red_acc_q;
    blue_acc_d = blue_acc_q;
    red_out_d  = red_out_q;
    blue_out_d = blue_out_q;
    if (vs_fall_s) begin
      red_acc_d  = '0;
      blue_acc_d = '0;
    end else if (w_en_d) begin
      if (is_red(pix_d[7:5], pix_d[1:0])) begin
        red_acc_d = red_acc_q + ADDR_W'(1);
      end else begin
        red_acc_d = red_acc_q;
      end
      if (is_blue(pix_d[7:5], pix_d[1:0])) begin
        blue_acc_d = blue_acc_q + ADDR_W'(1);
      end else begin
        blue_acc_d = blue_acc_q;
      end
    end else begin
      red_acc_d  = red_acc_q;
      blue_acc_d = blue_acc_q;
    end
    if (done_d) begin
      red_out_d  = red_acc_q;
      blue_out_d = blue_acc_q;
    end else begin
      red_out_d  = red_out_q;
      blue_out_d = blue_out_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      red_acc_q  <= '0;
      blue_acc_q <= '0;
      red_out_q  <= '0;
      blue_out_q <= '0;
    end else begin
      red_acc_q  <= red_acc_d;
      blue_acc_q <= blue_acc_d;
      red_out_q  <= red_out_d;
      blue_out_q <= blue_out_d;
    end
  end

  assign RED_COUNT  = red_out_q;
  assign BLUE_COUNT = blue_out_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
